// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and config-byte helpers for the UART command controller.
package uart_cmd_pkg;

  localparam logic [7:0] OP_WRITE = 8'hAA;
  localparam logic [7:0] OP_READ  = 8'hBB;
  localparam logic [7:0] OP_CFG   = 8'hCC;

  localparam int CFG_PAR_EN_BIT  = 0;
  localparam int CFG_PAR_TYP_BIT = 1;
  localparam int CFG_PRESC_LSB   = 2;
  localparam int CFG_PRESC_MSB   = 7;

  localparam logic [7:0] CFG_RESET = 8'h21;

  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_WAIT,
    S_TX_SEND,
    S_CFG_DATA
  } cmd_state_e;

  function automatic logic presc_legal(input logic [5:0] presc);
    return (presc == PRESC_8) || (presc == PRESC_16) || (presc == PRESC_32);
  endfunction

endpackage

// File: rtl/uart_rx_cmd_ctrl_if.sv
// Bundles the RX, register-file, TX and configuration signals around the command controller.
interface uart_rx_cmd_ctrl_if #(
  parameter int DATA_Width = 8,
  parameter int ADDR_Width = 4
);
  logic [DATA_Width-1:0] rx_p_data;
  logic                  rx_d_vld;
  logic                  rx_frm_err;
  logic                  wr_en;
  logic [ADDR_Width-1:0] wr_addr;
  logic [DATA_Width-1:0] wr_data;
  logic                  rd_en;
  logic [ADDR_Width-1:0] rd_addr;
  logic [DATA_Width-1:0] rd_data;
  logic                  rd_d_vld;
  logic [DATA_Width-1:0] tx_p_data;
  logic                  tx_d_vld;
  logic                  tx_busy;
  logic                  par_en;
  logic                  par_typ;
  logic [5:0]            prescale;
  logic                  cmd_err;

  modport master (
    input  rx_p_data, rx_d_vld, rx_frm_err, rd_data, rd_d_vld, tx_busy,
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_p_data, tx_d_vld,
           par_en, par_typ, prescale, cmd_err
  );

  modport slave (
    output rx_p_data, rx_d_vld, rx_frm_err, rd_data, rd_d_vld, tx_busy,
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, tx_p_data, tx_d_vld,
           par_en, par_typ, prescale, cmd_err
  );
endinterface

// File: rtl/uart_cmd_timer.sv
// Inter-byte timeout counter: held at zero when disabled or cleared, expires at CYCLES-1.
module uart_cmd_timer #(
  parameter int CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] count;

  // A byte arriving in the expiry cycle wins over the timeout.
  assign expire = enable && !clear && (count == W'(CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      count <= '0;
    end else if (!expire) begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/uart_rx_cmd_ctrl.sv
// Parses 2-3 byte UART command frames into register writes/reads, read-back TX and live config.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_rx_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int DATA_Width     = 8,
  parameter int ADDR_Width     = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic             clk,
  input logic             rst,
  uart_rx_cmd_ctrl_if.master bus
);
  cmd_state_e state, state_n;

  logic                  wr_en_q, wr_en_n;
  logic [ADDR_Width-1:0] wr_addr_q, wr_addr_n;
  logic [DATA_Width-1:0] wr_data_q, wr_data_n;
  logic                  rd_en_q, rd_en_n;
  logic [ADDR_Width-1:0] rd_addr_q, rd_addr_n;
  logic [DATA_Width-1:0] tx_data_q, tx_data_n;
  logic                  tx_vld_q, tx_vld_n;
  logic                  par_en_q, par_en_n;
  logic                  par_typ_q, par_typ_n;
  logic [5:0]            presc_q, presc_n;
  logic                  err_q, err_n;
  logic                  timeout;
  logic [7:0]            rx_byte;

  assign rx_byte = bus.rx_p_data[7:0];

`ifdef UART_CMD_TIMEOUT_EN
  logic timed;

  assign timed = (state == S_WR_ADDR) || (state == S_WR_DATA) || (state == S_RD_ADDR) ||
                 (state == S_CFG_DATA) || (state == S_RD_WAIT);

  uart_cmd_timer #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.rx_d_vld),
    .enable(timed),
    .expire(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    tx_vld_n  = 1'b0;
    err_n     = 1'b0;
    wr_addr_n = wr_addr_q;
    wr_data_n = wr_data_q;
    rd_addr_n = rd_addr_q;
    tx_data_n = tx_data_q;
    par_en_n  = par_en_q;
    par_typ_n = par_typ_q;
    presc_n   = presc_q;

    case (state)
      S_IDLE: begin
        if (bus.rx_frm_err) begin
          err_n = 1'b1;
        end else if (bus.rx_d_vld) begin
          case (rx_byte)
            OP_WRITE: state_n = S_WR_ADDR;
            OP_READ:  state_n = S_RD_ADDR;
            OP_CFG:   state_n = S_CFG_DATA;
            default:  err_n   = 1'b1;
          endcase
        end
      end
      S_WR_ADDR: begin
        if (bus.rx_frm_err || timeout) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (bus.rx_d_vld) begin
          wr_addr_n = bus.rx_p_data[ADDR_Width-1:0];
          state_n   = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (bus.rx_frm_err || timeout) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (bus.rx_d_vld) begin
          wr_data_n = bus.rx_p_data;
          wr_en_n   = 1'b1;
          state_n   = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (bus.rx_frm_err || timeout) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (bus.rx_d_vld) begin
          rd_addr_n = bus.rx_p_data[ADDR_Width-1:0];
          rd_en_n   = 1'b1;
          state_n   = S_RD_WAIT;
        end
      end
      // Framing errors are ignored here so an in-flight read still returns its byte.
      S_RD_WAIT: begin
        if (timeout) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (bus.rd_d_vld) begin
          tx_data_n = bus.rd_data;
          state_n   = S_TX_SEND;
        end
      end
      S_TX_SEND: begin
        if (!bus.tx_busy) begin
          tx_vld_n = 1'b1;
          state_n  = S_IDLE;
        end
      end
      S_CFG_DATA: begin
        if (bus.rx_frm_err || timeout) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else if (bus.rx_d_vld) begin
          state_n = S_IDLE;
          if (presc_legal(rx_byte[CFG_PRESC_MSB:CFG_PRESC_LSB])) begin
            par_en_n  = rx_byte[CFG_PAR_EN_BIT];
            par_typ_n = rx_byte[CFG_PAR_TYP_BIT];
            presc_n   = rx_byte[CFG_PRESC_MSB:CFG_PRESC_LSB];
          end else begin
            err_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      err_q     <= 1'b0;
      par_en_q  <= CFG_RESET[CFG_PAR_EN_BIT];
      par_typ_q <= CFG_RESET[CFG_PAR_TYP_BIT];
      presc_q   <= CFG_RESET[CFG_PRESC_MSB:CFG_PRESC_LSB];
    end else begin
      state     <= state_n;
      wr_en_q   <= wr_en_n;
      wr_addr_q <= wr_addr_n;
      wr_data_q <= wr_data_n;
      rd_en_q   <= rd_en_n;
      rd_addr_q <= rd_addr_n;
      tx_data_q <= tx_data_n;
      tx_vld_q  <= tx_vld_n;
      err_q     <= err_n;
      par_en_q  <= par_en_n;
      par_typ_q <= par_typ_n;
      presc_q   <= presc_n;
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.tx_p_data = tx_data_q;
  assign bus.tx_d_vld  = tx_vld_q;
  assign bus.par_en    = par_en_q;
  assign bus.par_typ   = par_typ_q;
  assign bus.prescale  = presc_q;
  assign bus.cmd_err   = err_q;
endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// Directed bench for uart_rx_cmd_ctrl: write, read-back, config, error, reset and timeout frames.
module tb_uart_rx_cmd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests    = 0;
  int failures = 0;
  int wr_cnt   = 0;
  int rd_cnt   = 0;
  int tx_cnt   = 0;
  int err_cnt  = 0;

  uart_rx_cmd_ctrl_if #(.DATA_Width(8), .ADDR_Width(4)) bus ();

  uart_rx_cmd_ctrl #(
    .DATA_Width    (8),
    .ADDR_Width    (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Strobe occurrence counters, sampled before each edge's update.
  always @(posedge clk) begin
    if (bus.wr_en)    wr_cnt++;
    if (bus.rd_en)    rd_cnt++;
    if (bus.tx_d_vld) tx_cnt++;
    if (bus.cmd_err)  err_cnt++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic frm);
    @(negedge clk);
    bus.rx_d_vld   = 1'b1;
    bus.rx_frm_err = frm;
    bus.rx_p_data  = b;
    @(negedge clk);
    bus.rx_d_vld   = 1'b0;
    bus.rx_frm_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wr0, rd0, tx0, err0;
    logic early_tx;

    bus.rx_p_data  = '0;
    bus.rx_d_vld   = 1'b0;
    bus.rx_frm_err = 1'b0;
    bus.rd_data    = '0;
    bus.rd_d_vld   = 1'b0;
    bus.tx_busy    = 1'b0;

    repeat (2) @(negedge clk);
    check_output("rst_wr_en",   bus.wr_en,     0);
    check_output("rst_rd_en",   bus.rd_en,     0);
    check_output("rst_tx_vld",  bus.tx_d_vld,  0);
    check_output("rst_cmd_err", bus.cmd_err,   0);
    check_output("rst_tx_data", bus.tx_p_data, 0);
    check_output("rst_par_en",  bus.par_en,    1);
    check_output("rst_par_typ", bus.par_typ,   0);
    check_output("rst_presc",   bus.prescale,  8);
    rst = 1'b0;

    // Write frame
    wr0 = wr_cnt;
    send_byte(8'hAA, 1'b0);
    send_byte(8'h05, 1'b0);
    check_output("wr_early", bus.wr_en, 0);
    send_byte(8'h3C, 1'b0);
    check_output("wr_en",   bus.wr_en,   1);
    check_output("wr_addr", bus.wr_addr, 5);
    check_output("wr_data", bus.wr_data, 8'h3C);
    @(negedge clk);
    check_output("wr_en_drop", bus.wr_en, 0);
    check_output("wr_pulses",  wr_cnt - wr0, 1);

    // Read frame with busy transmitter
    rd0 = rd_cnt;
    tx0 = tx_cnt;
    bus.tx_busy = 1'b1;
    send_byte(8'hBB, 1'b0);
    send_byte(8'h02, 1'b0);
    check_output("rd_en",   bus.rd_en,   1);
    check_output("rd_addr", bus.rd_addr, 2);
    @(negedge clk);
    @(negedge clk);
    bus.rd_d_vld = 1'b1;
    bus.rd_data  = 8'h7E;
    @(negedge clk);
    bus.rd_d_vld = 1'b0;
    bus.rd_data  = 8'h00;
    check_output("rd_capture", bus.tx_p_data, 8'h7E);
    early_tx = bus.tx_d_vld;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.tx_d_vld) early_tx = 1'b1;
    end
    check_output("tx_held_busy", early_tx, 0);
    bus.tx_busy = 1'b0;
    @(negedge clk);
    check_output("tx_vld",  bus.tx_d_vld,  1);
    check_output("tx_data", bus.tx_p_data, 8'h7E);
    @(negedge clk);
    check_output("tx_vld_drop", bus.tx_d_vld, 0);
    check_output("rd_pulses",   rd_cnt - rd0, 1);
    check_output("tx_pulses",   tx_cnt - tx0, 1);

    // Config accepted, then rejected
    send_byte(8'hCC, 1'b0);
    send_byte(8'h43, 1'b0);
    check_output("cfg_par_en",  bus.par_en,   1);
    check_output("cfg_par_typ", bus.par_typ,  1);
    check_output("cfg_presc",   bus.prescale, 16);
    check_output("cfg_no_err",  bus.cmd_err,  0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'h1B, 1'b0);
    check_output("cfg_bad_err",   bus.cmd_err,  1);
    check_output("cfg_bad_presc", bus.prescale, 16);
    check_output("cfg_bad_typ",   bus.par_typ,  1);
    @(negedge clk);
    check_output("cfg_err_drop", bus.cmd_err, 0);

    // Unknown opcode
    wr0 = wr_cnt; rd0 = rd_cnt; tx0 = tx_cnt;
    send_byte(8'h11, 1'b0);
    check_output("bad_op_err", bus.cmd_err, 1);
    @(negedge clk);
    check_output("bad_op_strobes", (wr_cnt - wr0) + (rd_cnt - rd0) + (tx_cnt - tx0), 0);

    // Framing error coincident with data byte
    wr0 = wr_cnt;
    send_byte(8'hAA, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h3C, 1'b1);
    check_output("frm_err", bus.cmd_err, 1);
    check_output("frm_no_wr", bus.wr_en, 0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h99, 1'b0);
    check_output("recov_wr_en",   bus.wr_en,   1);
    check_output("recov_wr_addr", bus.wr_addr, 7);
    check_output("recov_wr_data", bus.wr_data, 8'h99);
    @(negedge clk);
    check_output("frm_wr_pulses", wr_cnt - wr0, 1);

    // Reset in the middle of a write frame
    send_byte(8'hAA, 1'b0);
    send_byte(8'h05, 1'b0);
    wr0 = wr_cnt;
    rst = 1'b1;
    send_byte(8'h3C, 1'b0);
    check_output("mrst_wr_en",   bus.wr_en,    0);
    check_output("mrst_wr_addr", bus.wr_addr,  0);
    check_output("mrst_par_en",  bus.par_en,   1);
    check_output("mrst_par_typ", bus.par_typ,  0);
    check_output("mrst_presc",   bus.prescale, 8);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_output("mrst_no_wr", wr_cnt - wr0, 0);

    // Silence after an opcode
    err0 = err_cnt;
    send_byte(8'hAA, 1'b0);
    repeat (40) @(negedge clk);
`ifdef UART_CMD_TIMEOUT_EN
    check_output("timeout_err", err_cnt - err0, 1);
    send_byte(8'hAA, 1'b0);
`else
    check_output("no_timeout_err", err_cnt - err0, 0);
`endif
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    check_output("late_wr_en",   bus.wr_en,   1);
    check_output("late_wr_addr", bus.wr_addr, 1);
    check_output("late_wr_data", bus.wr_data, 2);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
